// File: rtl/pq_shift_array.sv
// Sorted shift-register priority queue, min key at the head.
// Package, key comparator and queue array in one file.
//
// pq_shift_array ports:
//   clk    in   rising-edge clock
//   rst_n  in   async active-low reset
//   enq    in   insert kvi this cycle
//   kvi    in   key/value to insert (kv_t)
//   deq    in   remove head this cycle
//   kvo    out  head entry (min key), valid when !empty
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  entries held
//   ovf    out  1-cycle pulse: enq dropped (full, no deq)
//   udf    out  1-cycle pulse: deq ignored (empty)

package pq_pkg;
    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;
endpackage

module pq_key_compare
    import pq_pkg::*;
(
    input  kv_t  a,
    input  kv_t  b,
    output logic a_lt_b
);
    // Strict less-than keeps equal keys in arrival order.
    assign a_lt_b = a.key < b.key;
endmodule

module pq_shift_array
    import pq_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enq,
    input  kv_t           kvi,
    input  logic          deq,
    output kv_t           kvo,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          udf
);
    kv_t             cell_q [DEPTH];
    kv_t             cell_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            udf_q;
    logic            udf_d;

    logic [DEPTH-1:0] cmp;
    // lt[DEPTH] is a sentinel so a full-array replace can land in the tail.
    logic [DEPTH:0]   lt;
    logic [DEPTH-1:0] ltp;
    kv_t              prv [DEPTH];
    kv_t              nxt [DEPTH];

    logic is_empty;
    logic is_full;
    logic do_enq;
    logic do_deq;
    logic do_rep;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    assign lt[DEPTH] = 1'b1;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        pq_key_compare u_cmp (
            .a      (kvi),
            .b      (cell_q[g]),
            .a_lt_b (cmp[g])
        );

        assign lt[g] = !vld_q[g] | cmp[g];

        if (g == 0) begin : g_head
            assign prv[g] = '0;
            assign ltp[g] = 1'b0;
        end else begin : g_body
            assign prv[g] = cell_q[g-1];
            assign ltp[g] = lt[g-1];
        end

        // Shifting left pulls in zero past the last valid entry so that
        // invalid cells (and kvo when empty) always read as zero.
        if (g == DEPTH - 1) begin : g_tail
            assign nxt[g] = '0;
        end else begin : g_mid
            assign nxt[g] = vld_q[g+1] ? cell_q[g+1] : '0;
        end
    end

    // Enq+deq on an empty queue degenerates to a plain insert at cell 0.
    assign do_rep = enq & deq & !is_empty;
    assign do_enq = enq & ((!deq & !is_full) | (deq & is_empty));
    assign do_deq = deq & !enq & !is_empty;

    always_comb begin
        count_d = count_q;
        if (do_enq) begin
            count_d = count_q + CW'(1);
        end else if (do_deq) begin
            count_d = count_q - CW'(1);
        end
        ovf_d = enq & !deq & is_full;
        udf_d = deq & is_empty;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cell_d[i] = cell_q[i];
            vld_d[i]  = (CW'(i) < count_d);
            unique case (1'b1)
                do_rep: begin
                    if (!lt[i+1]) begin
                        cell_d[i] = nxt[i];
                    end else if (!lt[i] || i == 0) begin
                        cell_d[i] = kvi;
                    end
                end
                do_enq: begin
                    if (lt[i]) begin
                        cell_d[i] = ltp[i] ? prv[i] : kvi;
                    end
                end
                do_deq: begin
                    cell_d[i] = nxt[i];
                end
                default: begin
                    cell_d[i] = cell_q[i];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cell_q[i] <= '0;
            end
            vld_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                cell_q[i] <= cell_d[i];
            end
            vld_q   <= vld_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign kvo   = cell_q[0];
    assign count = count_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign ovf   = ovf_q;
    assign udf   = udf_q;
endmodule

// File: tb/tb_pq_shift_array.sv
// Directed and random checks for pq_shift_array.
// Sorted-list model for the random phase.

module tb_pq_shift_array;
    import pq_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          enq;
    kv_t           kvi;
    logic          deq;
    kv_t           kvo;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;
    logic          udf;

    int checks;
    int failures;

    kv_t q[$];

    pq_shift_array #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enq   (enq),
        .kvi   (kvi),
        .deq   (deq),
        .kvo   (kvo),
        .full  (full),
        .empty (empty),
        .count (count),
        .ovf   (ovf),
        .udf   (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic kv_t mk(input int k, input int v);
        kv_t x;
        x.key = KEY_WIDTH'(k);
        x.val = VAL_WIDTH'(v);
        return x;
    endfunction

    task automatic op(input logic e, input logic d, input kv_t x);
        enq = e;
        deq = d;
        kvi = x;
        @(posedge clk);
        #1;
        enq = 1'b0;
        deq = 1'b0;
        kvi = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enq = 1'b0;
        deq = 1'b0;
        kvi = '0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== '0 ||
            kvo !== '0 || ovf !== 1'b0 || udf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got e=%b f=%b c=%0d kvo=%h o=%b u=%b exp 1 0 0 0 0 0",
                     empty, full, count, kvo, ovf, udf);
        end
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, mk(10 + i, i));
        checks++;
        if (count !== CW'(5)) begin
            failures++;
            $display("FAIL reset_prefill count got %0d exp 5", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== '0 || empty !== 1'b1 || kvo !== '0) begin
            failures++;
            $display("FAIL reset_async got c=%0d e=%b kvo=%h exp 0 1 0",
                     count, empty, kvo);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sort();
        int exp_k[4] = '{1, 3, 7, 9};
        op(1'b1, 1'b0, mk(7, 107));
        op(1'b1, 1'b0, mk(3, 103));
        op(1'b1, 1'b0, mk(9, 109));
        op(1'b1, 1'b0, mk(1, 101));
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (kvo !== mk(exp_k[i], exp_k[i] + 100) || count !== CW'(4 - i)) begin
                failures++;
                $display("FAIL sort_head[%0d] got kvo=%h c=%0d exp kvo=%h c=%0d",
                         i, kvo, count, mk(exp_k[i], exp_k[i] + 100), 4 - i);
            end
            op(1'b0, 1'b1, '0);
        end
        checks++;
        if (empty !== 1'b1 || count !== '0) begin
            failures++;
            $display("FAIL sort_empty got e=%b c=%0d exp 1 0", empty, count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, mk(i, 0));
        checks++;
        if (full !== 1'b1 || count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL full_fill got f=%b c=%0d exp 1 16", full, count);
        end
        op(1'b1, 1'b0, mk(5, 55));
        checks++;
        if (ovf !== 1'b1 || count !== CW'(DEPTH) || kvo !== mk(0, 0)) begin
            failures++;
            $display("FAIL full_ovf got o=%b c=%0d kvo=%h exp 1 16 0000",
                     ovf, count, kvo);
        end
        op(1'b1, 1'b1, mk(20, 0));
        checks++;
        if (ovf !== 1'b0 || count !== CW'(DEPTH) || kvo !== mk(1, 0)) begin
            failures++;
            $display("FAIL full_replace got o=%b c=%0d kvo=%h exp 0 16 0100",
                     ovf, count, kvo);
        end
        for (int i = 0; i < DEPTH; i++) begin
            int ek;
            ek = (i == DEPTH - 1) ? 20 : i + 1;
            checks++;
            if (kvo !== mk(ek, 0)) begin
                failures++;
                $display("FAIL full_drain[%0d] got %h exp %h", i, kvo, mk(ek, 0));
            end
            op(1'b0, 1'b1, '0);
        end
    endtask

    task automatic test_ties();
        op(1'b1, 1'b0, mk(4, 8'hA));
        op(1'b1, 1'b0, mk(4, 8'hB));
        op(1'b1, 1'b0, mk(4, 8'hC));
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (kvo !== mk(4, 8'hA + i)) begin
                failures++;
                $display("FAIL ties[%0d] got %h exp %h", i, kvo, mk(4, 8'hA + i));
            end
            op(1'b0, 1'b1, '0);
        end
    endtask

    task automatic test_replace();
        int exp_k[3] = '{1, 6, 8};
        op(1'b1, 1'b0, mk(2, 0));
        op(1'b1, 1'b0, mk(6, 0));
        op(1'b1, 1'b0, mk(8, 0));
        op(1'b1, 1'b1, mk(5, 0));
        checks++;
        if (kvo !== mk(5, 0) || count !== CW'(3)) begin
            failures++;
            $display("FAIL replace_5 got kvo=%h c=%0d exp 0500 3", kvo, count);
        end
        op(1'b1, 1'b1, mk(1, 0));
        checks++;
        if (kvo !== mk(1, 0) || count !== CW'(3)) begin
            failures++;
            $display("FAIL replace_1 got kvo=%h c=%0d exp 0100 3", kvo, count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (kvo !== mk(exp_k[i], 0)) begin
                failures++;
                $display("FAIL replace_drain[%0d] got %h exp %h",
                         i, kvo, mk(exp_k[i], 0));
            end
            op(1'b0, 1'b1, '0);
        end
    endtask

    task automatic test_empty();
        op(1'b0, 1'b1, '0);
        checks++;
        if (udf !== 1'b1 || count !== '0 || kvo !== '0) begin
            failures++;
            $display("FAIL empty_deq got u=%b c=%0d kvo=%h exp 1 0 0", udf, count, kvo);
        end
        op(1'b1, 1'b1, mk(3, 33));
        checks++;
        if (udf !== 1'b1 || count !== CW'(1) || kvo !== mk(3, 33)) begin
            failures++;
            $display("FAIL empty_replace got u=%b c=%0d kvo=%h exp 1 1 %h",
                     udf, count, kvo, mk(3, 33));
        end
        op(1'b0, 1'b1, '0);
        checks++;
        if (udf !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL empty_after got u=%b e=%b exp 0 1", udf, empty);
        end
    endtask

    function automatic void m_ins(input kv_t x);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].key > x.key) begin
                q.insert(i, x);
                return;
            end
        end
        q.push_back(x);
    endfunction

    task automatic test_random();
        q.delete();
        for (int c = 0; c < 4000; c++) begin
            logic e;
            logic d;
            logic eo;
            logic eu;
            kv_t x;
            int bias;
            bias = ((c / 250) % 2 == 0) ? 70 : 30;
            e = ($urandom_range(0, 99) < bias);
            d = ($urandom_range(0, 99) < 50);
            x = mk($urandom_range(0, 15), $urandom_range(0, 255));
            eo = 1'b0;
            eu = 1'b0;
            if (e && d) begin
                if (q.size() == 0) begin
                    eu = 1'b1;
                end else begin
                    void'(q.pop_front());
                end
                m_ins(x);
            end else if (e) begin
                if (q.size() == DEPTH) eo = 1'b1;
                else m_ins(x);
            end else if (d) begin
                if (q.size() == 0) eu = 1'b1;
                else void'(q.pop_front());
            end
            op(e, d, x);
            checks++;
            if (count !== CW'(q.size()) || ovf !== eo || udf !== eu ||
                empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
                (q.size() > 0 && kvo !== q[0])) begin
                failures++;
                $display("FAIL random[%0d] got c=%0d o=%b u=%b kvo=%h exp c=%0d o=%b u=%b kvo=%h",
                         c, count, ovf, udf, kvo, q.size(), eo, eu,
                         (q.size() > 0) ? q[0] : kv_t'(0));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        kvi = '0;
        test_reset();
        test_sort();
        test_full();
        test_ties();
        test_replace();
        test_empty();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
